// File: rtl/vga_pkg.sv
// vga_pkg: shared key codes, PS/2 set-2 scan constants and key decoder FSM states
package vga_pkg;
  localparam logic [3:0] key_relesed = 4'd0;
  localparam logic [3:0] key_A       = 4'd1;
  localparam logic [3:0] key_S       = 4'd2;
  localparam logic [3:0] key_W       = 4'd3;
  localparam logic [3:0] key_D       = 4'd4;
  localparam logic [3:0] key_1       = 4'd5;
  localparam logic [3:0] key_2       = 4'd6;
  localparam logic [3:0] key_3       = 4'd7;
  localparam logic [3:0] key_4       = 4'd8;
  localparam logic [3:0] key_esc     = 4'd9;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} kd_state_t;
endpackage

// File: rtl/key_scan_map.sv
// key_scan_map: combinational PS/2 set-2 scan byte to key code lookup
module key_scan_map
  import vga_pkg::*;
(
  input  logic [7:0] scan,
  output logic [3:0] key,
  output logic       mapped
);
  // translate the nine supported make codes; everything else is unmapped
  always_comb begin
    key = key_relesed;
    case (scan)
      SC_A:    key = key_A;
      SC_S:    key = key_S;
      SC_W:    key = key_W;
      SC_D:    key = key_D;
      SC_1:    key = key_1;
      SC_2:    key = key_2;
      SC_3:    key = key_3;
      SC_4:    key = key_4;
      SC_ESC:  key = key_esc;
      default: key = key_relesed;
    endcase
    mapped = key != key_relesed;
  end
endmodule

// File: rtl/key_decoder.sv
// key_decoder: PS/2 byte stream to held-key code; KEY_DECODER_TYPEMATIC_FILTER_EN suppresses repeat pulses
module key_decoder
  import vga_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 650_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] key_code,
  output logic       key_valid
);
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);

  kd_state_t   state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  key_q, key_d;
  logic        vld_q, vld_d;
  logic [3:0]  map_key;
  logic        map_hit;

  key_scan_map u_map (.scan(rx_data), .key(map_key), .mapped(map_hit));

  // next state: bytes always take priority over the prefix timeout
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    vld_d   = 1'b0;
    cnt_d   = (rx_valid || state_q == IDLE) ? 20'd0 : cnt_q + 20'd1;
    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          state_d = rx_data == SC_BREAK ? BREAK : rx_data == SC_EXT ? EXT : IDLE;
          if (rx_data != SC_BREAK && rx_data != SC_EXT && map_hit) begin
            key_d = map_key;
`ifdef KEY_DECODER_TYPEMATIC_FILTER_EN
            vld_d = map_key != key_q;
`else
            vld_d = 1'b1;
`endif
          end
        end
        BREAK: begin
          state_d = IDLE;
          if (map_hit && map_key == key_q) begin
            key_d = key_relesed;
            vld_d = 1'b1;
          end
        end
        EXT:       state_d = rx_data == SC_BREAK ? EXT_BREAK : IDLE;
        EXT_BREAK: state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end else if (state_q != IDLE && cnt_q == TO_LAST) begin
      state_d = IDLE;
    end
  end

  // state, timeout counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= key_relesed;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      vld_q   <= vld_d;
    end
  end

  assign key_code  = key_q;
  assign key_valid = vld_q;
endmodule
